// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field constants and flag decode.
package fp_pkg;

    localparam int FP_W    = 32;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int MAN_MSB = MAN_W - 1;
    localparam int EXP_LSB = MAN_W;
    localparam int EXP_MSB = MAN_W + EXP_W - 1;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_flags_t;

    function automatic fp_flags_t fp_classify(input logic [FP_W-1:0] v);
        fp_flags_t f;
        logic      e_max;
        logic      e_min;
        logic      m_nz;
        e_max  = &v[EXP_MSB:EXP_LSB];
        e_min  = ~|v[EXP_MSB:EXP_LSB];
        m_nz   = |v[MAN_MSB:0];
        f.nan  = e_max & m_nz;
        f.inf  = e_max & ~m_nz;
        f.zero = e_min & ~m_nz;
        return f;
    endfunction

endpackage

// File: rtl/FloatingPointAdder.sv
// Combinational single-precision adder, round-to-nearest-even.
module FloatingPointAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my;
    logic [27:0] acc;
    logic [24:0] rnd;
    logic [9:0]  e;
    logic        a_nan, b_nan, a_inf, b_inf;

    assign a_nan = (&a[30:23]) && (|a[22:0]);
    assign b_nan = (&b[30:23]) && (|b[22:0]);
    assign a_inf = (&a[30:23]) && !(|a[22:0]);
    assign b_inf = (&b[30:23]) && !(|b[22:0]);

    always_comb begin
        x  = (a[30:0] >= b[30:0]) ? a : b;
        y  = (a[30:0] >= b[30:0]) ? b : a;
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {|x[30:23], x[22:0], 3'b000};
        my = {|y[30:23], y[22:0], 3'b000};
        d  = ex - ey;
        // bit 0 acts as sticky while aligning the smaller operand
        for (int i = 0; i < 27; i++)
            if (i < int'(d))
                my = {1'b0, my[26:2], my[1] | my[0]};
        acc = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my}
                               : {1'b0, mx} - {1'b0, my};
        e = {2'b00, ex};
        if (acc[27]) begin
            acc = {1'b0, acc[27:2], acc[1] | acc[0]};
            e   = e + 10'd1;
        end
        for (int i = 0; i < 26; i++)
            if (!acc[26] && e > 10'd1) begin
                acc = {acc[26:0], 1'b0};
                e   = e - 10'd1;
            end
        rnd = {1'b0, acc[26:3]}
            + {24'd0, acc[2] & (acc[1] | acc[0] | acc[3])};
        if (rnd[24]) begin
            rnd = {1'b0, rnd[24:1]};
            e   = e + 10'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31]))
            sum = 32'h7FC0_0000;
        else if (a_inf)
            sum = a;
        else if (b_inf)
            sum = b;
        else if (acc == 28'd0)
            sum = {x[31] & y[31], 31'd0};
        else if (e >= 10'd255)
            sum = {x[31], 8'hFF, 23'd0};
        else
            sum = {x[31], rnd[23] ? e[7:0] : 8'h00, rnd[22:0]};
    end

endmodule

// File: rtl/fp_result_fifo.sv
// Synchronous result FIFO; head shows zero while empty.
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i)
                wptr_q <= wptr_q + PW'(1);
            if (pop_i)
                rptr_q <= rptr_q + PW'(1);
            if (push_i && !pop_i)
                count_q <= count_q + (PW+1)'(1);
            else if (pop_i && !push_i)
                count_q <= count_q - (PW+1)'(1);
        end
    end

    assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fp_add_sequencer.sv
// Credit-protected issue/collect wrapper around FloatingPointAdder.
// FP_ADD_SEQ_FLAGS_EN stores {nan,inf,zero} of each sum in the FIFO.
module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_a,
    input  logic [FP_W-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef FP_ADD_SEQ_FLAGS_EN
    localparam int ENT_W = FP_W + TAG_W + 3;
`else
    localparam int ENT_W = FP_W + TAG_W;
`endif

    logic [FP_W-1:0]  a_q, b_q, sum_q, sum_d;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic             v1_q, v2_q;
    logic             accept, pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit;
    logic [ENT_W-1:0] wdata, rdata;

    FloatingPointAdder u_add (
        .a   (a_q),
        .b   (b_q),
        .sum (sum_d)
    );

    // in-flight ops hold a FIFO slot so the FIFO can never overflow
    assign credit   = {1'b0, count} + (CNT_W+1)'(v1_q) + (CNT_W+1)'(v2_q);
    assign in_ready = credit < (CNT_W+1)'(FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            tag1_q <= '0;
            v1_q   <= 1'b0;
            sum_q  <= '0;
            tag2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                tag1_q <= in_tag;
            end
            v1_q   <= accept;
            sum_q  <= sum_d;
            tag2_q <= tag1_q;
            v2_q   <= v1_q;
        end
    end

`ifdef FP_ADD_SEQ_FLAGS_EN
    assign wdata = {sum_q, tag2_q, fp_classify(sum_q)};
    assign {out_sum, out_tag, out_flags} = rdata;
`else
    assign wdata = {sum_q, tag2_q};
    assign {out_sum, out_tag} = rdata;
    assign out_flags = 3'b000;
`endif

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (v2_q),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .count_o (count)
    );

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer with directed vectors.
module tb_fp_add_sequencer;

`ifdef FP_ADD_SEQ_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_a = 0;
    logic [31:0] in_b = 0;
    logic [3:0]  in_tag = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [31:0] out_sum;
    logic [3:0]  out_tag;
    logic [2:0]  out_flags;

    int total = 0;
    int bad = 0;
    int lowcnt = 0;
    bit streaming = 0;
    logic [38:0] exp_q[$];
    logic [31:0] tbl [10];

    always #5 clk = ~clk;

    fp_add_sequencer #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h/%h expected none",
                         out_sum, out_tag);
            end else begin
                chk("result", 64'({out_sum, out_tag, out_flags}),
                    64'(exp_q.pop_front()));
            end
        end
        if (streaming && !in_ready)
            lowcnt++;
    end

    // caller is at posedge+1; returns at the accept posedge+1
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] es,
                        input logic [2:0] ef);
        int n = 0;
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_tag = t;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(n), 64'(0));
            in_valid = 0;
        end else begin
            exp_q.push_back({es, t, FL ? ef : 3'b000});
            @(posedge clk);
            #1 in_valid = 0;
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = 0;
        tbl[0] = 32'h3F80_0000;
        tbl[1] = 32'h4000_0000;
        tbl[2] = 32'h4040_0000;
        tbl[3] = 32'h4080_0000;
        tbl[4] = 32'h40A0_0000;
        tbl[5] = 32'h40C0_0000;
        tbl[6] = 32'h40E0_0000;
        tbl[7] = 32'h4100_0000;
        tbl[8] = 32'h4110_0000;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_out_flags", 64'(out_flags), 64'(0));
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));

        send(32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 3'b000);
        @(negedge clk) chk("lat_n0", 64'(out_valid), 64'(0));
        @(negedge clk) chk("lat_n1", 64'(out_valid), 64'(0));
        @(negedge clk) chk("lat_n2", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        drain("drain_single");

        send(32'h3F80_0000, 32'hBF80_0000, 4'd1, 32'h0000_0000, 3'b001);
        send(32'h7F80_0000, 32'h3F80_0000, 4'd2, 32'h7F80_0000, 3'b010);
        send(32'h7FC0_0000, 32'h3F80_0000, 4'd3, 32'h7FC0_0000, 3'b100);
        send(32'h3FC0_0000, 32'h4010_0000, 4'd4, 32'h4070_0000, 3'b000);
        send(32'hC080_0000, 32'h3F80_0000, 4'd6, 32'hC040_0000, 3'b000);
        send(32'h3F00_0000, 32'h3E80_0000, 4'd7, 32'h3F40_0000, 3'b000);
        drain("drain_special");

        out_ready = 0;
        for (int k = 0; k < 4; k++)
            send(tbl[k], tbl[0], 4'(k), tbl[k+1], 3'b000);
        @(negedge clk) chk("bp_full", 64'(in_ready), 64'(0));
        repeat (3) @(negedge clk);
        chk("bp_hold_rdy", 64'(in_ready), 64'(0));
        chk("bp_hold_tag", 64'(out_tag), 64'(0));
        chk("bp_hold_sum", 64'(out_sum), 64'(tbl[1]));
        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 4; k < 8; k++)
                    send(tbl[k], tbl[0], 4'(k), tbl[k+1], 3'b000);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
                @(negedge clk) chk("bp_rdy_indep", 64'(in_ready), 64'(0));
                @(negedge clk) chk("bp_reopen", 64'(in_ready), 64'(1));
            end
        join
        drain("drain_bp");

        streaming = 1;
        for (int i = 0; i < 100; i++)
            send(tbl[i % 4], tbl[(i / 4) % 4], 4'(i),
                 tbl[(i % 4) + ((i / 4) % 4) + 1], 3'b000);
        streaming = 0;
        chk("stream_ready_low", 64'(lowcnt), 64'(0));
        drain("drain_stream");

        out_ready = 0;
        send(tbl[0], tbl[0], 4'd9, tbl[1], 3'b000);
        send(tbl[1], tbl[0], 4'd10, tbl[2], 3'b000);
        send(tbl[2], tbl[0], 4'd11, tbl[3], 3'b000);
        @(posedge clk);
        #1 rst_n = 0;
        exp_q.delete();
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_sum", 64'(out_sum), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("postrst_valid", 64'(out_valid), 64'(0));
        chk("postrst_ready", 64'(in_ready), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
